// File: rtl/imm_decode_stage.sv
// Registered immediate decoder: decodes the instruction immediate and format,
// then buffers the result in a 2-entry skid FIFO behind a valid/ready handshake.
module imm_decode_stage #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_J    = 3'b011;
    localparam logic [2:0] FMT_U    = 3'b100;
    localparam logic [2:0] FMT_SH   = 3'b101;
    localparam logic [2:0] FMT_ZIMM = 3'b110;
    localparam logic [2:0] FMT_NONE = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam bit IS64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            shift_f3;
    logic [2:0]      auto_fmt;
    logic            auto_ill;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] imm_q [2];
    logic [2:0]      fmt_q [2];
    logic            ill_q [2];
    logic            wptr;
    logic            rptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Derive the immediate format and legality from the opcode.
    always_comb begin
        auto_fmt = FMT_NONE;
        auto_ill = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: auto_fmt = FMT_I;
            OP_IMM:           auto_fmt = shift_f3 ? FMT_SH : FMT_I;
            OP_IMM32: begin
                if (IS64) auto_fmt = shift_f3 ? FMT_SH : FMT_I;
                else      auto_ill = 1'b1;
            end
            OP_SYSTEM:        auto_fmt = instr[14] ? FMT_ZIMM : FMT_I;
            OP_STORE:         auto_fmt = FMT_S;
            OP_BRANCH:        auto_fmt = FMT_B;
            OP_JAL:           auto_fmt = FMT_J;
            OP_LUI, OP_AUIPC: auto_fmt = FMT_U;
            default:          auto_ill = 1'b1;
        endcase
        // RV32 shift amounts only have 5 bits; bit 25 set is reserved.
        if (!IS64 && auto_fmt == FMT_SH && instr[25]) auto_ill = 1'b1;
    end

    assign dec_fmt = AUTO_DECODE ? auto_fmt : imm_src;
    assign dec_ill = AUTO_DECODE ? auto_ill : 1'b0;

    // Assemble and extend the immediate for the selected format.
    always_comb begin
        dec_imm = '0;
        case (dec_fmt)
            FMT_I: dec_imm = XLEN'($signed(instr[31:20]));
            FMT_S: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: dec_imm = XLEN'($signed({instr[31], instr[7],
                                            instr[30:25], instr[11:8],
                                            1'b0}));
            FMT_J: dec_imm = XLEN'($signed({instr[31], instr[19:12],
                                            instr[20], instr[30:21],
                                            1'b0}));
            FMT_U: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_SH: dec_imm = XLEN'({IS64 && instr[25], instr[24:20]});
            FMT_ZIMM: dec_imm = XLEN'(instr[19:15]);
            default: dec_imm = '0;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Two-slot FIFO: write at wptr, read at rptr, count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                ill_q[i] <= 1'b0;
            end
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                imm_q[wptr] <= dec_imm;
                fmt_q[wptr] <= dec_fmt;
                ill_q[wptr] <= dec_ill;
                wptr        <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign imm_ext = imm_q[rptr];
    assign imm_fmt = fmt_q[rptr];
    assign illegal = ill_q[rptr];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors for XLEN=32/64,
// manual format select, back-pressure, streaming and asynchronous reset.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_imm;
    logic [2:0]  a_fmt;
    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic        m_in_ready, m_out_valid, m_ill;
    logic [31:0] m_imm;
    logic [2:0]  m_fmt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b1)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid),
        .out_ready(out_ready), .imm_ext(a_imm), .imm_fmt(a_fmt),
        .illegal(a_ill)
    );

    imm_decode_stage #(.XLEN(64), .AUTO_DECODE(1'b1)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(b_out_valid),
        .out_ready(out_ready), .imm_ext(b_imm), .imm_fmt(b_fmt),
        .illegal(b_ill)
    );

    imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) um (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(m_out_valid),
        .out_ready(out_ready), .imm_ext(m_imm), .imm_fmt(m_fmt),
        .illegal(m_ill)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] e32;
        logic [2:0]  f32;
        logic        i32;
        logic [63:0] e64;
        logic [2:0]  f64;
        logic        i64;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk32(input string tag, input logic [31:0] e,
                         input logic [2:0] f, input logic il);
        chk({tag, " valid"}, 64'(a_out_valid), 64'd1);
        chk({tag, " imm"}, 64'(a_imm), 64'(e));
        chk({tag, " fmt"}, 64'(a_fmt), 64'(f));
        chk({tag, " ill"}, 64'(a_ill), 64'(il));
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0,
                     64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 1'b0,
                     64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
        vecs[2]  = '{32'h001000EF, 32'h00000800, 3'd3, 1'b0,
                     64'h800, 3'd3, 1'b0};
        vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0,
                     64'h12345000, 3'd4, 1'b0};
        vecs[4]  = '{32'h01F09093, 32'd31, 3'd5, 1'b0, 64'd31, 3'd5, 1'b0};
        vecs[5]  = '{32'h3402D073, 32'd5, 3'd6, 1'b0, 64'd5, 3'd6, 1'b0};
        vecs[6]  = '{32'h00000000, 32'd0, 3'd7, 1'b1, 64'd0, 3'd7, 1'b1};
        vecs[7]  = '{32'h02009093, 32'd0, 3'd5, 1'b1, 64'd32, 3'd5, 1'b0};
        vecs[8]  = '{32'h0000001B, 32'd0, 3'd7, 1'b1, 64'd0, 3'd0, 1'b0};
        vecs[9]  = '{32'h03F09093, 32'd31, 3'd5, 1'b1, 64'd63, 3'd5, 1'b0};
        vecs[10] = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0,
                     64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vecs[11] = '{32'h80000063, 32'hFFFFF000, 3'd2, 1'b0,
                     64'hFFFFFFFFFFFFF000, 3'd2, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        instr = '0;
        imm_src = 3'd0;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst out_valid", 64'(a_out_valid), 64'd0);
        chk("rst in_ready", 64'(a_in_ready), 64'd1);
        rst = 1'b0;
        cyc();
        chk("idle out_valid", 64'(a_out_valid), 64'd0);
        chk("idle imm", 64'(a_imm), 64'd0);
        chk("idle fmt", 64'(a_fmt), 64'd0);
        chk("idle ill", 64'(a_ill), 64'd0);

        // Table vectors, one instruction per cycle, both widths.
        for (int i = 0; i < 12; i++) begin
            instr = vecs[i].ins;
            in_valid = 1'b1;
            cyc();
            in_valid = 1'b0;
            chk32($sformatf("v%0d x32", i), vecs[i].e32, vecs[i].f32,
                  vecs[i].i32);
            chk($sformatf("v%0d x64 imm", i), b_imm, vecs[i].e64);
            chk($sformatf("v%0d x64 fmt", i), 64'(b_fmt), 64'(vecs[i].f64));
            chk($sformatf("v%0d x64 ill", i), 64'(b_ill), 64'(vecs[i].i64));
        end
        cyc();
        chk("drained", 64'(a_out_valid), 64'd0);

        // Manual format select.
        imm_src = 3'b010;
        instr = 32'h80000063;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("man B imm", 64'(m_imm), 64'hFFFFF000);
        chk("man B fmt", 64'(m_fmt), 64'd2);
        chk("man B ill", 64'(m_ill), 64'd0);
        imm_src = 3'b111;
        instr = 32'h00000000;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("man none imm", 64'(m_imm), 64'd0);
        chk("man none fmt", 64'(m_fmt), 64'd7);
        chk("man none ill", 64'(m_ill), 64'd0);
        imm_src = 3'b000;
        cyc();

        // Back-pressure: A, B fill the FIFO, C is held off.
        out_ready = 1'b0;
        instr = 32'h00500093;
        in_valid = 1'b1;
        cyc();
        chk("bp A ready", 64'(a_in_ready), 64'd1);
        chk32("bp A head", 32'd5, 3'd0, 1'b0);
        instr = 32'h00600093;
        cyc();
        chk("bp full ready", 64'(a_in_ready), 64'd0);
        instr = 32'h00700093;
        cyc();
        chk("bp hold ready", 64'(a_in_ready), 64'd0);
        chk32("bp hold head", 32'd5, 3'd0, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk32("bp B head", 32'd6, 3'd0, 1'b0);
        chk("bp recover", 64'(a_in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk32("bp C head", 32'd7, 3'd0, 1'b0);
        cyc();
        chk("bp empty", 64'(a_out_valid), 64'd0);

        // Streaming: simultaneous push and pop at count 1.
        for (int i = 1; i <= 10; i++) begin
            instr = 32'h00000093 | (32'(i) << 20);
            in_valid = 1'b1;
            cyc();
            chk32($sformatf("st%0d", i), 32'(i), 3'd0, 1'b0);
            chk($sformatf("st%0d ready", i), 64'(a_in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("st empty", 64'(a_out_valid), 64'd0);

        // Asynchronous reset mid-cycle with two entries held.
        out_ready = 1'b0;
        instr = 32'hFFF00093;
        in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        chk("pre-rst ready", 64'(a_in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(a_out_valid), 64'd0);
        chk("arst in_ready", 64'(a_in_ready), 64'd1);
        chk("arst imm", 64'(a_imm), 64'd0);
        chk("arst fmt", 64'(a_fmt), 64'd0);
        chk("arst imm64", b_imm, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        instr = 32'h123450B7;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk32("post-rst", 32'h12345000, 3'd4, 1'b0);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
